sm4_round_ctrl: RTL and testbench
=================================

# sm4_round_ctrl

Iterative SM4 block engine controller. Accepts one 128-bit block over a valid/ready handshake and holds the 32 round keys in an internal key file. It sequences 32 rounds of the SM4 round function, one round per clock, through a single shared round datapath (`sbox_32b` plus the linear transform L). It then applies the final reverse transform R and presents the result on a valid/ready output handshake. It sits between the key expansion/host loader and the downstream stream interface.

## Interface
Parameters:
- ROUNDS, 32, number of rounds sequenced; the counter width is fixed at 5 bits, so only 32 is supported.

Ports:
- CLK_i  input  1  clock; all state changes on the rising edge.
- RST_N_i  input  1  asynchronous, active-low reset.
- RK_WE_i  input  1  round-key write strobe.
- RK_ADDR_i  input  5  round-key index 0..31.
- RK_DAT_i  input  32  round-key value.
- MODE_i  input  1  0 = encrypt, 1 = decrypt; sampled at block accept.
- DAT_VALID_i  input  1  input block valid.
- DAT_READY_o  output  1  controller can accept a block.
- DAT_i  input  128  input block; DAT_i[127:96] is word X0.
- OUT_VALID_o  output  1  result valid.
- OUT_READY_i  input  1  downstream accepts the result.
- DAT_o  output  128  result block.
- BUSY_o  output  1  high in RUN.

## Operation
- The key file is 32 × 32-bit registers, async reset to 0.
  - A write on RK_WE_i is honoured in IDLE and DONE.
  - In RUN the write is dropped silently; the key file is unchanged.
- State X0..X3 is 128 bits. The round counter CNT is 5 bits. The mode latch is MODE_Q.
- FSM states are IDLE, RUN and DONE.
  - IDLE: DAT_READY_o = 1. When DAT_VALID_i & DAT_READY_o:
    - {X0,X1,X2,X3} ← DAT_i
    - CNT ← 0
    - MODE_Q ← MODE_i
    - go to RUN
  - RUN: each cycle, with rk = key[CNT] if MODE_Q = 0, else key[31−CNT]:
    - {X0,X1,X2,X3} ← {X1, X2, X3, X0 ^ L(τ(X1^X2^X3^rk))}
    - L(b) = b ^ (b<<<2) ^ (b<<<10) ^ (b<<<18) ^ (b<<<24)
    - CNT ← CNT+1
    - After the update with CNT = 31, go to DONE. CNT wraps to 0 and is unused in DONE.
  - DONE: OUT_VALID_o = 1 and DAT_o = {X3,X2,X1,X0}. When OUT_READY_i = 1, go to IDLE.
- DAT_o is registered.
  - It is updated only on the RUN→DONE transition.
  - It holds its last value in IDLE and RUN, and is stable while OUT_VALID_o = 1.
- DAT_VALID_i in RUN or DONE is ignored, because DAT_READY_o = 0. The upstream must hold DAT_i until accepted.
- A simultaneous RK_WE_i and block accept in IDLE both take effect. The new key is visible to round 0 if its address is the first key used.

## Timing
- Reset values:
  - DAT_READY_o = 1, OUT_VALID_o = 0, BUSY_o = 0, DAT_o = 0
  - state IDLE, CNT = 0, X = 0, MODE_Q = 0, key file all 0
- Latency: block accepted at edge E. RUN spans edges E+1..E+32. OUT_VALID_o is high after edge E+32.
- Throughput: if OUT_READY_i is held high, the block is consumed at edge E+33 and DAT_READY_o is high after it. That gives one block per 34 cycles.
- DAT_READY_o, OUT_VALID_o and BUSY_o are pure decodes of the state register, with no combinational path from inputs.
- Reset mid-operation (any state): returns immediately to reset values. A partially processed block is discarded and OUT_VALID_o never asserts for it.

## Configuration
- SM4_CTRL_DEC_EN
  - Defined: MODE_i is latched at accept, and MODE_Q = 1 reverses the key order (key[31−CNT]).
  - Undefined: the MODE_i port still exists but is ignored, MODE_Q is tied to 0, and only encryption is performed.

## Test plan
- Reset: assert RST_N_i low mid-clock → DAT_READY_o = 1, OUT_VALID_o = 0, BUSY_o = 0, DAT_o = 0 without waiting for a clock edge.
- Standard vector, encrypt: load the standard key-expansion round keys for key 0123456789abcdeffedcba9876543210 (rk0 = f12186f9 … rk31 = 9124a012). Send DAT_i = 0123456789abcdeffedcba9876543210 with MODE_i = 0 → OUT_VALID_o rises exactly 32 edges after accept, with DAT_o = 681edf34d206965e86b3e94f536e4246.
- Backpressure: hold OUT_READY_i = 0 for 10 cycles in DONE → DAT_o and OUT_VALID_o stay stable and DAT_READY_o = 0. Raise OUT_READY_i → IDLE the next cycle, and a back-to-back second block is accepted the following edge.
- Key write during RUN: at round 10, write RK_ADDR_i = 0, RK_DAT_i = 0 → the write is dropped, the result is still 681edf34…, and a second identical block gives the same result.
- Decrypt (SM4_CTRL_DEC_EN defined): MODE_i = 1, DAT_i = 681edf34d206965e86b3e94f536e4246 → DAT_o = 0123456789abcdeffedcba9876543210. With the macro undefined, the same stimulus produces encryption of that input.
- Reset mid-run: pulse RST_N_i low at round 15 → state returns to IDLE, OUT_VALID_o stays 0, and the key file reads back as 0. A subsequent accepted block runs the full 32 rounds.

Source files
------------

// File: rtl/sm4_round_ctrl_if.sv
// Host-side bundle for sm4_round_ctrl: key-file write port, block input and result handshakes.
// master = host/loader side, slave = controller side.
interface sm4_round_ctrl_if;
  logic         RK_WE_i;
  logic [4:0]   RK_ADDR_i;
  logic [31:0]  RK_DAT_i;
  logic         MODE_i;
  logic         DAT_VALID_i;
  logic         DAT_READY_o;
  logic [127:0] DAT_i;
  logic         OUT_VALID_o;
  logic         OUT_READY_i;
  logic [127:0] DAT_o;
  logic         BUSY_o;

  modport master (
    output RK_WE_i, RK_ADDR_i, RK_DAT_i, MODE_i, DAT_VALID_i, DAT_i, OUT_READY_i,
    input  DAT_READY_o, OUT_VALID_o, DAT_o, BUSY_o
  );

  modport slave (
    input  RK_WE_i, RK_ADDR_i, RK_DAT_i, MODE_i, DAT_VALID_i, DAT_i, OUT_READY_i,
    output DAT_READY_o, OUT_VALID_o, DAT_o, BUSY_o
  );
endinterface

// File: rtl/sm4_round_ctrl.sv
// Iterative SM4 block engine: 32 rounds, one per clock, through a single shared tau/L datapath.
// Optional macro SM4_CTRL_DEC_EN enables decryption (reversed round-key order selected by MODE_i).
module sm4_round_ctrl #(
  parameter int ROUNDS = 32
) (
  input logic             CLK_i,
  input logic             RST_N_i,
  sm4_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] sbox_32b(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] l_lin(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] x_q, x_d;
  logic [127:0] dat_o_q, dat_o_d;
  logic         mode_q;
  logic [31:0]  key_q [32];
  logic [31:0]  key_d [32];

  logic         accept;
  logic         last_round;
  logic         key_we;
  logic [4:0]   rk_idx;
  logic [31:0]  rk;
  logic [31:0]  x_new;

  assign accept     = (state_q == IDLE) && bus.DAT_VALID_i;
  assign last_round = (cnt_q == 5'(ROUNDS - 1));
  assign key_we     = bus.RK_WE_i && (state_q != RUN);

  // Decrypt walks the key file backwards; 31-CNT is the bitwise complement for a 5-bit counter.
  assign rk_idx = mode_q ? ~cnt_q : cnt_q;
  assign rk     = key_q[rk_idx];
  assign x_new  = x_q[127:96] ^ l_lin(sbox_32b(x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk));

`ifdef SM4_CTRL_DEC_EN
  logic mode_d;

  always_comb begin
    mode_d = mode_q;
    if (accept) mode_d = bus.MODE_i;
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) mode_q <= 1'b0;
    else          mode_q <= mode_d;
  end
`else
  logic unused_mode;
  assign unused_mode = bus.MODE_i;
  assign mode_q      = 1'b0;
`endif

  always_comb begin
    key_d = key_q;
    if (key_we) key_d[bus.RK_ADDR_i] = bus.RK_DAT_i;
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      for (int i = 0; i < 32; i++) key_q[i] <= '0;
    end else begin
      key_q <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    dat_o_d = dat_o_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d     = bus.DAT_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d   = {x_q[95:0], x_new};
        cnt_d = cnt_q + 5'd1;
        // Result word order is reversed (R transform) as it is captured.
        if (last_round) begin
          state_d = DONE;
          dat_o_d = {x_new, x_q[31:0], x_q[63:32], x_q[95:64]};
        end
      end
      DONE: begin
        if (bus.OUT_READY_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      dat_o_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      dat_o_q <= dat_o_d;
    end
  end

  assign bus.DAT_READY_o = (state_q == IDLE);
  assign bus.BUSY_o      = (state_q == RUN);
  assign bus.OUT_VALID_o = (state_q == DONE);
  assign bus.DAT_o       = dat_o_q;

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Scoreboard bench for sm4_round_ctrl: stimulus pushes expected results, a negedge monitor checks them.
// Expected values come from a word-list SM4 model; decrypt expectations follow SM4_CTRL_DEC_EN.
module tb_sm4_round_ctrl;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  localparam logic [127:0] STD_PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_CT = 128'h681edf34d206965e86b3e94f536e4246;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm4_round_ctrl_if bus();

  sm4_round_ctrl #(.ROUNDS(32)) dut (
    .CLK_i   (clk),
    .RST_N_i (rst_n),
    .bus     (bus)
  );

  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic [31:0]  kf [32];
  logic [31:0]  std_rk [32];
  logic         prev_valid = 1'b0;
  logic [127:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = SBOX[a[8*j +: 8]];
    return r;
  endfunction

  // Textbook formulation: X[i+4] = X[i] ^ T(X[i+1]^X[i+2]^X[i+3]^rk[i]), output {X35,X34,X33,X32}.
  function automatic logic [127:0] sm4_model(input logic [127:0] blk, input logic mode);
    logic [31:0] x [36];
    logic [31:0] b;
    logic [31:0] rk;
    for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      rk = mode ? kf[31-i] : kf[i];
      b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk);
      x[i+4] = x[i] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic expand_std_keys();
    logic [127:0] mk;
    logic [31:0]  fk [4];
    logic [31:0]  k [36];
    logic [31:0]  ck;
    logic [31:0]  b;
    mk = STD_PT;
    fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
      b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      std_rk[i] = k[i+4];
    end
  endtask

  task automatic write_key(input logic [4:0] a, input logic [31:0] d, input bit honoured);
    @(negedge clk);
    bus.RK_WE_i   = 1'b1;
    bus.RK_ADDR_i = a;
    bus.RK_DAT_i  = d;
    @(posedge clk);
    #1 bus.RK_WE_i = 1'b0;
    if (honoured) kf[a] = d;
  endtask

  task automatic applyStimulus(input logic [127:0] blk, input logic mode, input bit ovr,
                               input logic [127:0] ovr_val, input bit wr, input logic [4:0] wa,
                               input logic [31:0] wd);
    int   n;
    logic em;
    n = 0;
    while (!bus.DAT_READY_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.DAT_READY_o) begin
      check("accept_timeout", bus.DAT_READY_o, 1);
      return;
    end
    bus.DAT_VALID_i = 1'b1;
    bus.DAT_i       = blk;
    bus.MODE_i      = mode;
    if (wr) begin
      bus.RK_WE_i   = 1'b1;
      bus.RK_ADDR_i = wa;
      bus.RK_DAT_i  = wd;
      kf[wa] = wd;
    end
`ifdef SM4_CTRL_DEC_EN
    em = mode;
`else
    em = 1'b0;
`endif
    exp_q.push_back(ovr ? ovr_val : sm4_model(blk, em));
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    bus.DAT_VALID_i = 1'b0;
    bus.RK_WE_i     = 1'b0;
  endtask

  task automatic checkOutput(input int hold);
    int n;
    n = 0;
    bus.OUT_READY_i = (hold == 0);
    while (!bus.OUT_VALID_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.OUT_VALID_o) begin
      check("result_timeout", bus.OUT_VALID_o, 1);
      bus.OUT_READY_i = 1'b1;
      return;
    end
    repeat (hold) @(negedge clk);
    bus.OUT_READY_i = 1'b1;
    @(negedge clk);
    check("ready_after_consume", bus.DAT_READY_o, 1);
    check("valid_after_consume", bus.OUT_VALID_o, 0);
  endtask

  // Monitor: status one-hot every cycle, result/latency on each new valid, stability while held.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      check("status_onehot", int'(bus.DAT_READY_o) + int'(bus.BUSY_o) + int'(bus.OUT_VALID_o), 1);
      if (bus.OUT_VALID_o && !prev_valid) begin
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("dat_o", bus.DAT_o, exp_q.pop_front());
          check("latency", cyc - acc_q.pop_front(), 32);
        end
        held = bus.DAT_o;
      end else if (bus.OUT_VALID_o) begin
        check("dat_o_stable", bus.DAT_o, held);
      end
      prev_valid = bus.OUT_VALID_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] blk;
    bus.RK_WE_i     = 1'b0;
    bus.RK_ADDR_i   = '0;
    bus.RK_DAT_i    = '0;
    bus.MODE_i      = 1'b0;
    bus.DAT_VALID_i = 1'b0;
    bus.DAT_i       = '0;
    bus.OUT_READY_i = 1'b1;
    for (int i = 0; i < 32; i++) kf[i] = '0;
    expand_std_keys();

    #7;
    check("rst_ready", bus.DAT_READY_o, 1);
    check("rst_valid", bus.OUT_VALID_o, 0);
    check("rst_busy", bus.BUSY_o, 0);
    check("rst_dat_o", bus.DAT_o, 0);
    #5 rst_n = 1'b1;

    for (int i = 0; i < 32; i++) write_key(5'(i), std_rk[i], 1'b1);

    $display("[TB] standard encrypt vector");
    applyStimulus(STD_PT, 1'b0, 1'b1, STD_CT, 1'b0, '0, '0);
    checkOutput(0);

    $display("[TB] backpressure then back-to-back block");
    applyStimulus(STD_PT, 1'b0, 1'b1, STD_CT, 1'b0, '0, '0);
    checkOutput(10);
    blk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(blk, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    checkOutput(0);

    $display("[TB] key write dropped during RUN");
    applyStimulus(STD_PT, 1'b0, 1'b1, STD_CT, 1'b0, '0, '0);
    repeat (10) @(negedge clk);
    write_key(5'd0, 32'h0, 1'b0);
    checkOutput(0);
    applyStimulus(STD_PT, 1'b0, 1'b1, STD_CT, 1'b0, '0, '0);
    checkOutput(0);

    $display("[TB] decrypt vector");
`ifdef SM4_CTRL_DEC_EN
    applyStimulus(STD_CT, 1'b1, 1'b1, STD_PT, 1'b0, '0, '0);
`else
    applyStimulus(STD_CT, 1'b1, 1'b0, '0, 1'b0, '0, '0);
`endif
    checkOutput(0);

    $display("[TB] key write coincident with accept");
    blk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(blk, 1'b0, 1'b0, '0, 1'b1, 5'd0, $urandom);
    checkOutput(0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(blk, 1'b1, 1'b0, '0, 1'b1, 5'd31, $urandom);
    checkOutput(0);

    $display("[TB] randomized blocks");
    for (int t = 0; t < 10; t++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) write_key(5'($urandom_range(0, 31)), $urandom, 1'b1);
      blk = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(blk, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, '0, '0);
      checkOutput($urandom_range(0, 3));
    end

    $display("[TB] reset mid-run");
    blk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(blk, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", bus.DAT_READY_o, 1);
    check("midrst_valid", bus.OUT_VALID_o, 0);
    check("midrst_busy", bus.BUSY_o, 0);
    check("midrst_dat_o", bus.DAT_o, 0);
    exp_q.delete();
    acc_q.delete();
    for (int i = 0; i < 32; i++) kf[i] = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_stale_valid", bus.OUT_VALID_o, 0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(blk, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    checkOutput(0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(blk, 1'b1, 1'b0, '0, 1'b0, '0, '0);
    checkOutput(0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
